// File: rtl/gfx_frame_arbiter.sv
// gfx_frame_arbiter: frame-atomic round-robin arbiter that shares
// the framebuffer pixel-write port between two pixel sources.
module gfx_frame_arbiter #(
    parameter int FB_WIDTH   = 640,
    parameter int FB_HEIGHT  = 480,
    parameter int PIXEL_BITS = 12,
    parameter int FB_X_BITS  = $clog2(FB_WIDTH),
    parameter int FB_Y_BITS  = $clog2(FB_HEIGHT)
) (
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic                  s0_valid,
    output logic                  s0_ready,
    input  logic [FB_X_BITS-1:0]  s0_x,
    input  logic [FB_Y_BITS-1:0]  s0_y,
    input  logic [PIXEL_BITS-1:0] s0_color,
    input  logic                  s0_last,
    input  logic                  s1_valid,
    output logic                  s1_ready,
    input  logic [FB_X_BITS-1:0]  s1_x,
    input  logic [FB_Y_BITS-1:0]  s1_y,
    input  logic [PIXEL_BITS-1:0] s1_color,
    input  logic                  s1_last,
    output logic                  m_valid,
    input  logic                  m_ready,
    output logic [FB_X_BITS-1:0]  m_x,
    output logic [FB_Y_BITS-1:0]  m_y,
    output logic [PIXEL_BITS-1:0] m_color,
    output logic                  m_last,
    output logic                  grant_active,
    output logic                  grant_src,
    output logic                  frame_done,
    output logic                  range_err
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_OWN0 = 2'd1,
        ST_OWN1 = 2'd2
    } state_t;

    localparam logic [31:0] X_LIM = FB_WIDTH;
    localparam logic [31:0] Y_LIM = FB_HEIGHT;

    state_t state_q, state_d;

    logic                  prio_q, prio_d;
    logic                  grant_src_q, grant_src_d;
    logic                  m_valid_q, m_valid_d;
    logic [FB_X_BITS-1:0]  m_x_q, m_x_d;
    logic [FB_Y_BITS-1:0]  m_y_q, m_y_d;
    logic [PIXEL_BITS-1:0] m_color_q, m_color_d;
    logic                  m_last_q, m_last_d;
    logic                  frame_done_q, frame_done_d;
    logic                  range_err_q, range_err_d;

    logic                  out_free;
    logic                  sel_valid;
    logic [FB_X_BITS-1:0]  sel_x;
    logic [FB_Y_BITS-1:0]  sel_y;
    logic [PIXEL_BITS-1:0] sel_color;
    logic                  sel_last;
    logic                  acc;
    logic                  in_range;

    // Owner's beat mux and accept/range qualification.
    always_comb begin
        out_free  = !m_valid_q || m_ready;
        sel_valid = 1'b0;
        sel_x     = s0_x;
        sel_y     = s0_y;
        sel_color = s0_color;
        sel_last  = s0_last;
        if (state_q == ST_OWN0) begin
            sel_valid = s0_valid;
        end else if (state_q == ST_OWN1) begin
            sel_valid = s1_valid;
            sel_x     = s1_x;
            sel_y     = s1_y;
            sel_color = s1_color;
            sel_last  = s1_last;
        end
        acc      = sel_valid && out_free;
        in_range = (32'(sel_x) < X_LIM) && (32'(sel_y) < Y_LIM);
    end

    // State register.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next state: grant in IDLE, release on an accepted last beat.
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: begin
                if (s0_valid && s1_valid) begin
                    state_d = prio_q ? ST_OWN1 : ST_OWN0;
                end else if (s0_valid) begin
                    state_d = ST_OWN0;
                end else if (s1_valid) begin
                    state_d = ST_OWN1;
                end
            end
            ST_OWN0, ST_OWN1: begin
                if (acc && sel_last) begin
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // FSM outputs: only the owner sees ready, gated by output space.
    always_comb begin
        s0_ready     = 1'b0;
        s1_ready     = 1'b0;
        grant_active = 1'b0;
        case (state_q)
            ST_OWN0: begin
                grant_active = 1'b1;
                s0_ready     = out_free;
            end
            ST_OWN1: begin
                grant_active = 1'b1;
                s1_ready     = out_free;
            end
            default: ;
        endcase
    end

    // Datapath next values: output stage, priority, owner, status.
    always_comb begin
        m_valid_d    = m_valid_q;
        m_x_d        = m_x_q;
        m_y_d        = m_y_q;
        m_color_d    = m_color_q;
        m_last_d     = m_last_q;
        prio_d       = prio_q;
        grant_src_d  = grant_src_q;
        range_err_d  = range_err_q;
        frame_done_d = m_valid_q && m_ready && m_last_q;

        if (acc && in_range) begin
            m_valid_d = 1'b1;
            m_x_d     = sel_x;
            m_y_d     = sel_y;
            m_color_d = sel_color;
            m_last_d  = sel_last;
        end else if (m_valid_q && m_ready) begin
            m_valid_d = 1'b0;
        end

        if (acc && !in_range) begin
            range_err_d = 1'b1;
            if (sel_last) begin
                frame_done_d = 1'b1;
            end
        end

        if (acc && sel_last) begin
            prio_d = (state_q == ST_OWN0);
        end

        if (state_d == ST_OWN0) begin
            grant_src_d = 1'b0;
        end else if (state_d == ST_OWN1) begin
            grant_src_d = 1'b1;
        end
    end

    // Datapath registers.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            prio_q       <= 1'b0;
            grant_src_q  <= 1'b0;
            m_valid_q    <= 1'b0;
            m_x_q        <= '0;
            m_y_q        <= '0;
            m_color_q    <= '0;
            m_last_q     <= 1'b0;
            frame_done_q <= 1'b0;
            range_err_q  <= 1'b0;
        end else begin
            prio_q       <= prio_d;
            grant_src_q  <= grant_src_d;
            m_valid_q    <= m_valid_d;
            m_x_q        <= m_x_d;
            m_y_q        <= m_y_d;
            m_color_q    <= m_color_d;
            m_last_q     <= m_last_d;
            frame_done_q <= frame_done_d;
            range_err_q  <= range_err_d;
        end
    end

    assign m_valid    = m_valid_q;
    assign m_x        = m_x_q;
    assign m_y        = m_y_q;
    assign m_color    = m_color_q;
    assign m_last     = m_last_q;
    assign grant_src  = grant_src_q;
    assign frame_done = frame_done_q;
    assign range_err  = range_err_q;

endmodule

// File: tb/tb_gfx_frame_arbiter.sv
// tb_gfx_frame_arbiter: directed bench for the frame-atomic arbiter
// on a 4x2 framebuffer, with a small in-order output scoreboard.
module tb_gfx_frame_arbiter;

    localparam int W  = 4;
    localparam int H  = 2;
    localparam int XB = 3;
    localparam int YB = 2;
    localparam int PB = 12;

    typedef struct packed {
        logic [XB-1:0] x;
        logic [YB-1:0] y;
        logic [PB-1:0] c;
        logic          l;
    } beat_t;

    logic          clk = 1'b0;
    logic          reset_n = 1'b0;
    logic          s0_valid = 1'b0, s0_ready, s0_last = 1'b0;
    logic [XB-1:0] s0_x = '0;
    logic [YB-1:0] s0_y = '0;
    logic [PB-1:0] s0_color = '0;
    logic          s1_valid = 1'b0, s1_ready, s1_last = 1'b0;
    logic [XB-1:0] s1_x = '0;
    logic [YB-1:0] s1_y = '0;
    logic [PB-1:0] s1_color = '0;
    logic          m_valid, m_ready = 1'b1, m_last;
    logic [XB-1:0] m_x;
    logic [YB-1:0] m_y;
    logic [PB-1:0] m_color;
    logic          grant_active, grant_src, frame_done, range_err;

    gfx_frame_arbiter #(
        .FB_WIDTH(W), .FB_HEIGHT(H), .PIXEL_BITS(PB),
        .FB_X_BITS(XB), .FB_Y_BITS(YB)
    ) dut (
        .clk(clk), .reset_n(reset_n),
        .s0_valid(s0_valid), .s0_ready(s0_ready),
        .s0_x(s0_x), .s0_y(s0_y), .s0_color(s0_color),
        .s0_last(s0_last),
        .s1_valid(s1_valid), .s1_ready(s1_ready),
        .s1_x(s1_x), .s1_y(s1_y), .s1_color(s1_color),
        .s1_last(s1_last),
        .m_valid(m_valid), .m_ready(m_ready),
        .m_x(m_x), .m_y(m_y), .m_color(m_color), .m_last(m_last),
        .grant_active(grant_active), .grant_src(grant_src),
        .frame_done(frame_done), .range_err(range_err)
    );

    always #5 clk = ~clk;

    int    n_checks = 0;
    int    n_errors = 0;
    beat_t q0[$], q1[$], exp_q[$];
    logic  en0 = 1'b0, en1 = 1'b0, mr_mode = 1'b0;
    logic  fd_exp = 1'b0, hold_chk = 1'b0;
    beat_t held;
    int    cyc = 0, fd_cnt = 0;
    logic  lg_s0r[0:63], lg_s1r[0:63], lg_mv[0:63];
    logic  lg_ga[0:63], lg_gs[0:63], lg_fd[0:63], lg_re[0:63];

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s cyc=%0d got=%0h exp=%0h", tag, cyc, got, exp);
        end
    endtask

    function automatic beat_t mk(input int x, input int y,
                                 input int c, input bit l);
        beat_t b;
        b.x = XB'(x);
        b.y = YB'(y);
        b.c = PB'(c);
        b.l = l;
        return b;
    endfunction

    function automatic bit inr(input beat_t b);
        return (int'(b.x) < W) && (int'(b.y) < H);
    endfunction

    task automatic start_test();
        cyc      = 0;
        fd_cnt   = 0;
        fd_exp   = 1'b0;
        hold_chk = 1'b0;
        exp_q.delete();
    endtask

    task automatic apply_reset();
        reset_n  = 1'b0;
        s0_valid = 1'b0;
        s1_valid = 1'b0;
        m_ready  = 1'b1;
        en0      = 1'b0;
        en1      = 1'b0;
        mr_mode  = 1'b0;
        q0.delete();
        q1.delete();
        repeat (2) @(posedge clk);
        @(negedge clk);
        reset_n = 1'b1;
        @(posedge clk);
        #1;
        start_test();
    endtask

    // One cycle: drive at posedge+1, check at negedge, retire at posedge.
    task automatic step();
        beat_t b0, b1, mb;
        logic  a0, a1;
        b0 = (q0.size() > 0) ? q0[0] : '0;
        b1 = (q1.size() > 0) ? q1[0] : '0;
        s0_valid = en0 && (q0.size() > 0);
        s0_x = b0.x; s0_y = b0.y; s0_color = b0.c; s0_last = b0.l;
        s1_valid = en1 && (q1.size() > 0);
        s1_x = b1.x; s1_y = b1.y; s1_color = b1.c; s1_last = b1.l;
        m_ready = mr_mode ? (cyc % 3 == 0) : 1'b1;
        @(negedge clk);
        a0 = s0_valid && s0_ready;
        a1 = s1_valid && s1_ready;
        if (cyc < 64) begin
            lg_s0r[cyc] = s0_ready;
            lg_s1r[cyc] = s1_ready;
            lg_mv[cyc]  = m_valid;
            lg_ga[cyc]  = grant_active;
            lg_gs[cyc]  = grant_src;
            lg_fd[cyc]  = frame_done;
            lg_re[cyc]  = range_err;
        end
        chk("excl_ready", s0_ready && s1_ready, 0);
        chk("frame_done", frame_done, fd_exp);
        if (frame_done) fd_cnt++;
        mb = {m_x, m_y, m_color, m_last};
        if (hold_chk) chk("hold", {m_valid, mb}, {1'b1, held});
        hold_chk = m_valid && !m_ready;
        held = mb;
        if (grant_active && !grant_src)
            chk("s0_ready_mirror", s0_ready, !m_valid || m_ready);
        if (grant_active && grant_src)
            chk("s1_ready_mirror", s1_ready, !m_valid || m_ready);
        if (m_valid && m_ready) begin
            if (exp_q.size() == 0) chk("sb_extra", 1, 0);
            else chk("sb_beat", mb, exp_q.pop_front());
        end
        fd_exp = (m_valid && m_ready && m_last)
               || (a0 && !inr(b0) && b0.l)
               || (a1 && !inr(b1) && b1.l);
        @(posedge clk);
        #1;
        if (a0) begin
            void'(q0.pop_front());
            if (inr(b0)) exp_q.push_back(b0);
        end
        if (a1) begin
            void'(q1.pop_front());
            if (inr(b1)) exp_q.push_back(b1);
        end
        cyc++;
    endtask

    task automatic run(input int n);
        for (int i = 0; i < n; i++) step();
    endtask

    task automatic push_frame(input bit src, input int n, input int c0);
        for (int i = 0; i < n; i++) begin
            if (src) q1.push_back(mk(i % W, i / W, c0 + i, i == n - 1));
            else     q0.push_back(mk(i % W, i / W, c0 + i, i == n - 1));
        end
    endtask

    initial begin
        // Reset state
        @(negedge clk);
        chk("rst_m_valid", m_valid, 0);
        chk("rst_ready", {s0_ready, s1_ready, grant_active}, 0);
        chk("rst_regs", {m_x, m_y, m_color, m_last, grant_src,
                         frame_done, range_err}, 0);

        // Single source, full 4x2 frame
        apply_reset();
        push_frame(0, 8, 'h100);
        en0 = 1'b1;
        run(13);
        chk("t1_s0r_c0", lg_s0r[0], 0);
        chk("t1_s0r_c1", lg_s0r[1], 1);
        chk("t1_mv_c1", lg_mv[1], 0);
        chk("t1_mv_c2", lg_mv[2], 1);
        chk("t1_mv_c9", lg_mv[9], 1);
        chk("t1_mv_c10", lg_mv[10], 0);
        chk("t1_ga_c9", lg_ga[9], 0);
        chk("t1_fd_c9", lg_fd[9], 0);
        chk("t1_fd_c10", lg_fd[10], 1);
        chk("t1_gs", lg_gs[10], 0);
        chk("t1_drain", exp_q.size(), 0);

        // Simultaneous requests, round-robin
        apply_reset();
        push_frame(0, 3, 'h200);
        push_frame(0, 3, 'h210);
        push_frame(1, 3, 'h300);
        en0 = 1'b1;
        en1 = 1'b1;
        run(14);
        chk("t2_s0r_c1", lg_s0r[1], 1);
        chk("t2_s1r_c1", lg_s1r[1], 0);
        chk("t2_ga_c4", lg_ga[4], 0);
        chk("t2_s1r_c5", lg_s1r[5], 1);
        chk("t2_gs_c5", lg_gs[5], 1);
        chk("t2_gs_c8", lg_gs[8], 1);
        chk("t2_s0r_c9", lg_s0r[9], 1);
        chk("t2_gs_c9", lg_gs[9], 0);
        chk("t2_q_empty", q0.size() + q1.size(), 0);

        // Backpressure on the output port
        apply_reset();
        push_frame(0, 8, 'h400);
        en0 = 1'b1;
        mr_mode = 1'b1;
        run(40);
        chk("t3_q_empty", q0.size(), 0);
        chk("t3_drain", exp_q.size(), 0);
        chk("t3_fd_cnt", fd_cnt, 1);

        // Out-of-range beats, including a dropped last
        apply_reset();
        q1.push_back(mk(4, 0, 'h500, 0));
        q1.push_back(mk(0, 1, 'h501, 0));
        q1.push_back(mk(1, 1, 'h502, 1));
        q1.push_back(mk(2, 0, 'h503, 0));
        q1.push_back(mk(1, 2, 'h504, 1));
        en1 = 1'b1;
        run(10);
        chk("t4_s1r_c1", lg_s1r[1], 1);
        chk("t4_re_c1", lg_re[1], 0);
        chk("t4_re_c2", lg_re[2], 1);
        chk("t4_mv_c2", lg_mv[2], 0);
        chk("t4_mv_c3", lg_mv[3], 1);
        chk("t4_fd_c5", lg_fd[5], 1);
        chk("t4_mv_c6", lg_mv[6], 1);
        chk("t4_mv_c7", lg_mv[7], 0);
        chk("t4_fd_c7", lg_fd[7], 1);
        chk("t4_re_end", range_err, 1);
        chk("t4_fd_cnt", fd_cnt, 2);

        // Reset mid-frame after a completed frame left prio at 1
        apply_reset();
        push_frame(0, 2, 'h600);
        push_frame(0, 8, 'h610);
        en0 = 1'b1;
        run(7);
        chk("t5_pre_mv", m_valid, 1);
        chk("t5_pre_ga", grant_active, 1);
        #2;
        reset_n = 1'b0;
        #1;
        chk("t5_rst_mv", m_valid, 0);
        chk("t5_rst_rdy", {s0_ready, s1_ready, grant_active}, 0);
        chk("t5_rst_data", {m_x, m_y, m_color, m_last}, 0);
        apply_reset();
        push_frame(0, 2, 'h620);
        push_frame(1, 2, 'h630);
        en0 = 1'b1;
        en1 = 1'b1;
        run(8);
        chk("t5_s0r_c1", lg_s0r[1], 1);
        chk("t5_s1r_c1", lg_s1r[1], 0);
        chk("t5_gs_c1", lg_gs[1], 0);
        chk("t5_s1r_c4", lg_s1r[4], 1);
        chk("t5_gs_c4", lg_gs[4], 1);

        // Back-to-back frames from source 1 alone
        apply_reset();
        push_frame(1, 2, 'h700);
        push_frame(1, 2, 'h710);
        en1 = 1'b1;
        run(10);
        chk("t6_s1r_c1", lg_s1r[1], 1);
        chk("t6_gs_c1", lg_gs[1], 1);
        chk("t6_ga_c3", lg_ga[3], 0);
        chk("t6_s1r_c4", lg_s1r[4], 1);
        chk("t6_fd_c4", lg_fd[4], 1);
        chk("t6_fd_c7", lg_fd[7], 1);
        chk("t6_fd_cnt", fd_cnt, 2);
        chk("t6_drain", exp_q.size(), 0);

        $display("Simulation finished: %0d checks, %0d errors",
                 n_checks, n_errors);
        $finish;
    end

endmodule
